serdes_tx_scheduler: RTL and testbench

SERDES_TX_SCHEDULER -- requirements
Module: serdes_tx_scheduler

---
 rtl/serdes_tx_scheduler.sv | 72 +++++++
 tb/tb_serdes_tx_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_tx_scheduler.sv
// serdes_tx_scheduler: per-slot word scheduler for a serializer, sync words after reset then round-robin A/B data or idle
module serdes_tx_scheduler #(
    parameter logic [7:0]  SYNC_PATTERN = 8'hBC,
    parameter logic [7:0]  IDLE_PATTERN = 8'h00,
    parameter int unsigned SYNC_WORDS   = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        en,
    input  logic [7:0]  a_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [7:0]  b_data,
    input  logic        b_valid,
    output logic        b_ready,
    output logic [7:0]  ser_data,
    output logic        ser_load,
    output logic        ser_is_data,
    output logic        ser_src,
    output logic        sync_done,
    output logic [15:0] tx_count
);
    localparam logic [0:0] SYNC = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [3:0] sync_cnt;
    logic       last_b;
    logic       dec;
    logic       sync_last;
    logic       grant;
    logic       pick_b;
    always_comb begin
        dec       = bit_cnt == 3'd7;
        sync_last = sync_cnt == 4'(SYNC_WORDS);
        grant     = dec && state == RUN && en && (a_valid || b_valid);
        pick_b    = b_valid && (!a_valid || !last_b);
        a_ready   = grant && !pick_b;
        b_ready   = grant && pick_b;
    end
    assign sync_done = state == RUN;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= SYNC;
            bit_cnt     <= 3'd7;
            sync_cnt    <= 4'd0;
            last_b      <= 1'b1;
            ser_data    <= 8'h00;
            ser_load    <= 1'b0;
            ser_is_data <= 1'b0;
            ser_src     <= 1'b0;
            tx_count    <= 16'd0;
        end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            ser_load <= dec;
            if (dec) begin
                ser_is_data <= grant;
                ser_src     <= b_ready;
                ser_data    <= grant ? (pick_b ? b_data : a_data) :
                               (state == SYNC && !sync_last) ? SYNC_PATTERN : IDLE_PATTERN;
                if (state == SYNC && !sync_last)
                    sync_cnt <= sync_cnt + 4'd1;
                if (state == SYNC && sync_last)
                    state <= RUN;
                if (grant) begin
                    tx_count <= tx_count + 16'd1;
                    last_b   <= pick_b;
                end
            end
        end
    end
endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// tb_serdes_tx_scheduler: slot-level reference model plus directed vectors for the serdes_tx_scheduler
`timescale 1ns/1ps
module tb_serdes_tx_scheduler;
    localparam int         SW = 4;
    localparam logic [7:0] SP = 8'hBC;
    localparam logic [7:0] IP = 8'h00;
    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        en = 1'b0;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic [7:0]  a_data = 8'h00;
    logic [7:0]  b_data = 8'h00;
    logic        a_ready, b_ready, ser_load, ser_is_data, ser_src, sync_done;
    logic [7:0]  ser_data;
    logic [15:0] tx_count;
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          slots = 0;
    logic        m_last_b = 1'b1;
    logic        m_is = 1'b0;
    logic        m_src = 1'b0;
    logic [7:0]  m_data = 8'h00;
    logic [15:0] m_cnt = 16'd0;

    typedef struct {
        logic        en, av, bv;
        logic [7:0]  ad, bd;
        logic        ra, rb;
        logic [7:0]  data;
        logic        is, src;
        logic [15:0] cnt;
    } vec_t;
    vec_t tv[10];

    serdes_tx_scheduler #(.SYNC_PATTERN(SP), .IDLE_PATTERN(IP), .SYNC_WORDS(SW)) dut (
        .clk(clk), .nreset(nreset), .en(en),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .ser_data(ser_data), .ser_load(ser_load), .ser_is_data(ser_is_data),
        .ser_src(ser_src), .sync_done(sync_done), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: slots counts decision edges since reset; the first SW carry sync words,
    // the next one is the idle hand-over word, later ones arbitrate.
    task automatic ref_cycle();
        logic run, dec, g, gb;
        if (!nreset) begin
            cyc = 0; slots = 0; m_last_b = 1'b1; m_is = 1'b0; m_src = 1'b0; m_data = 8'h00; m_cnt = 16'd0;
            chk("rst_a_ready", 32'(a_ready), 32'(1'b0));
            chk("rst_b_ready", 32'(b_ready), 32'(1'b0));
            chk("rst_ser_load", 32'(ser_load), 32'(1'b0));
            chk("rst_ser_data", 32'(ser_data), 32'(8'h00));
            chk("rst_sync_done", 32'(sync_done), 32'(1'b0));
            chk("rst_tx_count", 32'(tx_count), 32'(16'd0));
            return;
        end
        run = slots > SW;
        dec = cyc % 8 == 0;
        g = dec && run && en && (a_valid || b_valid);
        if (a_valid && b_valid) gb = !m_last_b;
        else gb = b_valid;
        gb = g && gb;
        chk("a_ready", 32'(a_ready), 32'(g && !gb));
        chk("b_ready", 32'(b_ready), 32'(gb));
        chk("ser_load", 32'(ser_load), 32'(cyc % 8 == 1));
        chk("ser_data", 32'(ser_data), 32'(m_data));
        chk("ser_is_data", 32'(ser_is_data), 32'(m_is));
        chk("ser_src", 32'(ser_src), 32'(m_src));
        chk("sync_done", 32'(sync_done), 32'(run));
        chk("tx_count", 32'(tx_count), 32'(m_cnt));
        if (dec) begin
            slots++;
            m_is = g;
            m_src = gb;
            m_data = g ? (gb ? b_data : a_data) : ((slots <= SW) ? SP : IP);
            if (g) begin
                m_cnt++;
                m_last_b = gb;
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(negedge clk);
        ref_cycle();
    end

    task automatic to_bit(input int b);
        do begin
            @(posedge clk);
            #1;
        end while ((cyc + 7) % 8 != b);
    endtask

    task automatic do_reset(input int hold);
        nreset = 1'b0;
        #1;
        chk("async_ser_data", 32'(ser_data), 32'(8'h00));
        chk("async_ser_load", 32'(ser_load), 32'(1'b0));
        chk("async_is_data", 32'(ser_is_data), 32'(1'b0));
        chk("async_src", 32'(ser_src), 32'(1'b0));
        chk("async_sync_done", 32'(sync_done), 32'(1'b0));
        chk("async_tx_count", 32'(tx_count), 32'(16'd0));
        chk("async_readies", 32'(a_ready | b_ready), 32'(1'b0));
        repeat (hold) @(posedge clk);
        #1 nreset = 1'b1;
    endtask

    initial begin
        int rdy;
        tv[0] = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h33, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 16'd2};
        tv[1] = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h33, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 16'd3};
        tv[2] = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd3};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 16'd4};
        tv[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 16'd5};
        tv[5] = '{1'b1, 1'b1, 1'b0, 8'h66, 8'h00, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 16'd6};
        tv[6] = '{1'b1, 1'b0, 1'b0, 8'h66, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd6};
        tv[7] = '{1'b1, 1'b1, 1'b1, 8'h77, 8'h88, 1'b0, 1'b1, 8'h88, 1'b1, 1'b1, 16'd7};
        tv[8] = '{1'b1, 1'b1, 1'b1, 8'h99, 8'hAA, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 16'd8};
        tv[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd8};
        #1;
        do_reset(2);
        // sync phase: loads at 1, 9, 17, 25, hand-over idle at 33
        rdy = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c % 8 == 1 && c <= 25) begin
                chk("sync_load", 32'(ser_load), 32'(1'b1));
                chk("sync_word", 32'(ser_data), 32'(SP));
                chk("sync_done_early", 32'(sync_done), 32'(1'b0));
            end
            if (c == 33) begin
                chk("run_load", 32'(ser_load), 32'(1'b1));
                chk("run_idle_word", 32'(ser_data), 32'(IP));
                chk("run_sync_done", 32'(sync_done), 32'(1'b1));
            end
            rdy += int'(a_ready | b_ready);
        end
        chk("sync_no_ready", 32'(rdy), 32'(0));
        // single A request raised mid-slot
        en = 1'b1;
        to_bit(2);
        a_valid = 1'b1;
        a_data = 8'h22;
        #1;
        for (int k = 2; k < 7; k++) begin
            chk("a_ready_early", 32'(a_ready), 32'(1'b0));
            @(posedge clk);
            #1;
        end
        chk("a_ready_decision", 32'(a_ready), 32'(1'b1));
        chk("b_ready_idle", 32'(b_ready), 32'(1'b0));
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("a_word", 32'(ser_data), 32'(8'h22));
        chk("a_is_data", 32'(ser_is_data), 32'(1'b1));
        chk("a_src", 32'(ser_src), 32'(1'b0));
        chk("a_count", 32'(tx_count), 32'(16'd1));
        // table of slots starting from last grant = A, tx_count = 1
        for (int i = 0; i < 10; i++) begin
            en = tv[i].en; a_valid = tv[i].av; b_valid = tv[i].bv; a_data = tv[i].ad; b_data = tv[i].bd;
            to_bit(7);
            chk("tv_a_ready", 32'(a_ready), 32'(tv[i].ra));
            chk("tv_b_ready", 32'(b_ready), 32'(tv[i].rb));
            to_bit(0);
            chk("tv_data", 32'(ser_data), 32'(tv[i].data));
            chk("tv_is_data", 32'(ser_is_data), 32'(tv[i].is));
            chk("tv_src", 32'(ser_src), 32'(tv[i].src));
            chk("tv_count", 32'(tx_count), 32'(tv[i].cnt));
        end
        // en low holds A off for three slots
        en = 1'b0; a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_bit(7);
            chk("en_off_ready", 32'(a_ready), 32'(1'b0));
            to_bit(0);
            chk("en_off_idle", 32'(ser_data), 32'(IP));
            chk("en_off_count", 32'(tx_count), 32'(16'd8));
        end
        en = 1'b1;
        to_bit(7);
        chk("en_on_ready", 32'(a_ready), 32'(1'b1));
        to_bit(0);
        a_valid = 1'b0;
        chk("en_on_word", 32'(ser_data), 32'(8'h5A));
        chk("en_on_count", 32'(tx_count), 32'(16'd9));
        // reset in the middle of a data slot with B still requesting
        b_valid = 1'b1; b_data = 8'hC3;
        to_bit(7);
        to_bit(0);
        chk("b_word", 32'(ser_data), 32'(8'hC3));
        to_bit(3);
        do_reset(2);
        rdy = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c < 40) rdy += int'(b_ready);
            else chk("b_ready_after_resync", 32'(b_ready), 32'(1'b1));
        end
        chk("b_ready_during_sync", 32'(rdy), 32'(0));
        // both requesters continuously valid from a fresh reset
        do_reset(2);
        a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h33; en = 1'b1;
        while (cyc < 33) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 6; k++) begin
            to_bit(7);
            chk("alt_a_ready", 32'(a_ready), 32'(k % 2 == 0));
            chk("alt_b_ready", 32'(b_ready), 32'(k % 2 == 1));
            to_bit(0);
            chk("alt_word", 32'(ser_data), 32'((k % 2 == 1) ? 8'h33 : 8'h11));
        end
        chk("alt_count", 32'(tx_count), 32'(16'd6));
        // counter wrap: preload the count instead of issuing 65 535 grants
        a_valid = 1'b0; b_valid = 1'b0;
        force dut.tx_count = 16'hFFFF;
        #1;
        release dut.tx_count;
        m_cnt = 16'hFFFF;
        #1;
        chk("wrap_preload", 32'(tx_count), 32'(16'hFFFF));
        a_valid = 1'b1; a_data = 8'hE7;
        to_bit(7);
        to_bit(0);
        a_valid = 1'b0;
        chk("wrap_count", 32'(tx_count), 32'(16'd0));
        chk("wrap_word", 32'(ser_data), 32'(8'hE7));
        // random traffic, including protocol violations and rare resets
        for (int i = 0; i < 2400; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) en = $urandom_range(0, 4) != 0;
            if ($urandom_range(0, 3) == 0) a_valid = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) b_valid = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0) a_data = 8'($urandom);
            if ($urandom_range(0, 2) == 0) b_data = 8'($urandom);
            if ($urandom_range(0, 799) == 0) do_reset(2);
        end
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
